// File: rtl/freq_meas_scheduler.sv
// Time-shares one frequency counter across NCH pulse sources: sweeps the enabled
// channels in ascending order, averages 2**NSAMP_LOG2 periods each and reports one result per channel.
module freq_meas_scheduler #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned NSAMP_LOG2 = 2,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NCH-1:0]   chan_mask,
    output logic             busy,
    output logic             meas_en,
    output logic [CH_W-1:0]  meas_sel,
    input  logic             meas_vld,
    input  logic [CNT_W-1:0] meas_cnt,
    output logic             res_vld,
    output logic [CH_W-1:0]  res_chan,
    output logic [CNT_W-1:0] res_avg,
    output logic             res_timeout,
    output logic             done
);

    localparam int unsigned ACC_W  = CNT_W + NSAMP_LOG2;
    localparam int unsigned SAMP_W = (NSAMP_LOG2 > 0) ? NSAMP_LOG2 : 1;
    localparam int unsigned TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'((1 << NSAMP_LOG2) - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_REPORT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state, state_nxt;
    logic [NCH-1:0]    mask_q, mask_nxt;
    logic              arm_cnt, arm_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt, acc_sum;
    logic [SAMP_W-1:0] samp, samp_nxt;
    logic [TO_W-1:0]   tcnt, tcnt_nxt;
    logic [CH_W-1:0]   sel_nxt, res_chan_nxt;
    logic [CNT_W-1:0]  res_avg_nxt;
    logic              res_to_nxt;
    logic              first_found, nxt_found;
    logic [CH_W-1:0]   first_ch, nxt_ch;

    assign acc_sum = acc + ACC_W'(meas_cnt);

    // Channel search: lowest bit of the incoming mask, and next latched bit above meas_sel
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        nxt_found   = 1'b0;
        nxt_ch      = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(meas_sel))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        mask_nxt     = mask_q;
        arm_nxt      = arm_cnt;
        acc_nxt      = acc;
        samp_nxt     = samp;
        tcnt_nxt     = tcnt;
        sel_nxt      = meas_sel;
        res_chan_nxt = res_chan;
        res_avg_nxt  = res_avg;
        res_to_nxt   = res_timeout;
        case (state)
            S_IDLE: begin
                arm_nxt = 1'b0;
                if (start) begin
                    mask_nxt = chan_mask;
                    if (first_found) begin
                        sel_nxt   = first_ch;
                        state_nxt = S_ARM;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_ARM: begin
                acc_nxt  = '0;
                samp_nxt = '0;
                tcnt_nxt = '0;
                arm_nxt  = 1'b1;
                if (arm_cnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                tcnt_nxt = tcnt + 1'b1;
                if (meas_vld) begin
                    acc_nxt  = acc_sum;
                    samp_nxt = samp + 1'b1;
                end
                // A final sample on the timeout cycle still yields a valid result
                if (meas_vld && (samp == SAMP_LAST)) begin
                    state_nxt    = S_REPORT;
                    res_chan_nxt = meas_sel;
                    res_avg_nxt  = acc_sum[ACC_W-1:NSAMP_LOG2];
                    res_to_nxt   = 1'b0;
                end else if (tcnt == TO_LAST) begin
                    state_nxt    = S_REPORT;
                    res_chan_nxt = meas_sel;
                    res_avg_nxt  = '0;
                    res_to_nxt   = 1'b1;
                end
            end
            S_REPORT: begin
                arm_nxt = 1'b0;
                if (nxt_found) begin
                    sel_nxt   = nxt_ch;
                    state_nxt = S_ARM;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered datapath and outputs, aligned with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q      <= '0;
            arm_cnt     <= 1'b0;
            acc         <= '0;
            samp        <= '0;
            tcnt        <= '0;
            busy        <= 1'b0;
            meas_en     <= 1'b0;
            meas_sel    <= '0;
            res_vld     <= 1'b0;
            res_chan    <= '0;
            res_avg     <= '0;
            res_timeout <= 1'b0;
            done        <= 1'b0;
        end else begin
            mask_q      <= mask_nxt;
            arm_cnt     <= arm_nxt;
            acc         <= acc_nxt;
            samp        <= samp_nxt;
            tcnt        <= tcnt_nxt;
            busy        <= (state_nxt != S_IDLE);
            meas_en     <= (state_nxt == S_WAIT);
            meas_sel    <= sel_nxt;
            res_vld     <= (state_nxt == S_REPORT);
            res_chan    <= res_chan_nxt;
            res_avg     <= res_avg_nxt;
            res_timeout <= res_to_nxt;
            done        <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Bench for freq_meas_scheduler: a behavioural pulse/counter model feeds the DUT,
// expected results are queued per sweep and compared as res_vld strobes arrive.
module tb_freq_meas_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned TO  = 200;

    typedef struct packed {
        logic [1:0]  chan;
        logic [15:0] avg;
        logic        to;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  chan_mask = '0;
    logic        busy, meas_en, res_vld, res_timeout, done;
    logic [1:0]  meas_sel, res_chan;
    logic        meas_vld = 1'b0;
    logic [15:0] meas_cnt = '0;
    logic [15:0] res_avg;

    int checks = 0;
    int errors = 0;
    int res_seen = 0;
    int done_seen = 0;

    res_t        exp_q[$];
    logic [15:0] samp_q[$];
    logic [15:0] per [NCH];
    int          gap = 0;
    logic [1:0]  prev_sel = '0;

    freq_meas_scheduler #(
        .NCH(4), .CH_W(2), .CNT_W(16), .NSAMP_LOG2(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask),
        .busy(busy), .meas_en(meas_en), .meas_sel(meas_sel),
        .meas_vld(meas_vld), .meas_cnt(meas_cnt),
        .res_vld(res_vld), .res_chan(res_chan), .res_avg(res_avg),
        .res_timeout(res_timeout), .done(done)
    );

    always #5 clk = ~clk;

    // Counter model: a sample every per[sel] enabled cycles, value from samp_q or the period
    always @(negedge clk) begin
        if (!meas_en) begin
            gap      = 0;
            meas_vld = 1'b0;
        end else begin
            gap++;
            if (per[meas_sel] != 0 && gap >= int'(per[meas_sel])) begin
                gap      = 0;
                meas_vld = 1'b1;
                if (samp_q.size() > 0) meas_cnt = samp_q.pop_front();
                else                   meas_cnt = per[meas_sel];
            end else begin
                meas_vld = 1'b0;
            end
        end
    end

    // Scoreboard: every result strobe must match the oldest expectation
    always @(negedge clk) begin
        res_t got;
        res_t e;
        if (done) done_seen++;
        if (res_vld) begin
            res_seen++;
            got = {res_chan, res_avg, res_timeout};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result chan=%0d avg=%0d to=%b", res_chan, res_avg, res_timeout);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL result got chan=%0d avg=%0d to=%b expected chan=%0d avg=%0d to=%b",
                             got.chan, got.avg, got.to, e.chan, e.avg, e.to);
                end
            end
        end
        // The pulse mux may only move while the counter is disabled
        if (!rst && meas_sel !== prev_sel) begin
            checks++;
            if (meas_en !== 1'b0) begin
                errors++;
                $display("FAIL sel_change_while_en sel=%0d meas_en=%b expected 0", meas_sel, meas_en);
            end
        end
        prev_sel = meas_sel;
    end

    task automatic pulse_start(input logic [3:0] m);
        @(negedge clk);
        start     = 1'b1;
        chan_mask = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < NCH; i++) per[i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, meas_en, meas_sel, res_vld, res_chan, res_avg, res_timeout, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b en=%b sel=%0d vld=%b avg=%0d done=%b expected all 0",
                     busy, meas_en, meas_sel, res_vld, res_avg, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int n;
        per[0] = 16'd10;
        exp_q.push_back('{chan: 2'd0, avg: 16'd10, to: 1'b0});
        pulse_start(4'b0001);
        checks++;
        if (busy !== 1'b1 || meas_en !== 1'b0) begin
            errors++;
            $display("FAIL single_arm1 busy=%b en=%b expected 1 0", busy, meas_en);
        end
        @(negedge clk);
        checks++;
        if (meas_en !== 1'b0) begin
            errors++;
            $display("FAIL single_arm2 en=%b expected 0", meas_en);
        end
        @(negedge clk);
        checks++;
        if (meas_en !== 1'b1) begin
            errors++;
            $display("FAIL single_wait_en en=%b expected 1", meas_en);
        end
        n = 0;
        while (!done && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_done done=%b pending=%0d expected 1 0", done, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_two_channel;
        int n;
        int r0;
        int d0;
        per[0] = 16'd10;
        per[1] = 16'd7;
        per[2] = 16'd5;
        per[3] = 16'd20;
        r0 = res_seen;
        d0 = done_seen;
        exp_q.push_back('{chan: 2'd1, avg: 16'd7,  to: 1'b0});
        exp_q.push_back('{chan: 2'd3, avg: 16'd20, to: 1'b0});
        pulse_start(4'b1010);
        repeat (5) @(negedge clk);
        // Start and mask change mid-sweep must both be ignored
        pulse_start(4'b1111);
        n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || exp_q.size() != 0 || res_seen - r0 != 2) begin
            errors++;
            $display("FAIL two_done done=%b pending=%0d results=%0d expected 1 0 2",
                     done, exp_q.size(), res_seen - r0);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_seen - d0 != 1) begin
            errors++;
            $display("FAIL two_no_restart busy=%b dones=%0d expected 0 1", busy, done_seen - d0);
        end
    endtask

    task automatic test_timeout;
        int n;
        int wc;
        per[2] = '0;
        exp_q.push_back('{chan: 2'd2, avg: 16'd0, to: 1'b1});
        pulse_start(4'b0100);
        n  = 0;
        wc = 0;
        while (!res_vld && n < 1000) begin
            @(negedge clk);
            n++;
            if (meas_en) wc++;
        end
        checks++;
        if (res_vld !== 1'b1 || wc != int'(TO)) begin
            errors++;
            $display("FAIL timeout_latency res_vld=%b wait_cycles=%0d expected 1 %0d", res_vld, wc, TO);
        end
        n = 0;
        while (!done && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_done done=%b pending=%0d expected 1 0", done, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_empty;
        int n;
        int r0;
        int d0;
        r0 = res_seen;
        d0 = done_seen;
        pulse_start(4'b0000);
        n = 0;
        while (!done && n < 2) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL empty_done done=%b expected 1", done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_seen != r0 || done_seen - d0 != 1) begin
            errors++;
            $display("FAIL empty_after busy=%b results=%0d dones=%0d expected 0 0 1",
                     busy, res_seen - r0, done_seen - d0);
        end
    endtask

    task automatic test_average;
        int n;
        per[0] = 16'd5;
        samp_q = '{16'd9, 16'd10, 16'd11, 16'd12};
        exp_q.push_back('{chan: 2'd0, avg: 16'd10, to: 1'b0});
        pulse_start(4'b0001);
        n = 0;
        while (!done && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || exp_q.size() != 0 || samp_q.size() != 0) begin
            errors++;
            $display("FAIL average_done done=%b pending=%0d samples_left=%0d expected 1 0 0",
                     done, exp_q.size(), samp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_coincident;
        int n;
        // Period 50: fourth sample lands on the last WAIT cycle, so the result is valid
        per[0] = 16'd50;
        exp_q.push_back('{chan: 2'd0, avg: 16'd50, to: 1'b0});
        pulse_start(4'b0001);
        n = 0;
        while (!done && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL coincident_done done=%b pending=%0d expected 1 0", done, exp_q.size());
        end
        @(negedge clk);
        per[0] = 16'd51;
        exp_q.push_back('{chan: 2'd0, avg: 16'd0, to: 1'b1});
        pulse_start(4'b0001);
        n = 0;
        while (!done && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL late_sample_done done=%b pending=%0d expected 1 0", done, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        int d0;
        int r0;
        per[0] = 16'd10;
        pulse_start(4'b0001);
        n = 0;
        while (!meas_en && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        d0 = done_seen;
        r0 = res_seen;
        rst = 1'b1;
        #1;
        checks++;
        if ({meas_en, busy, res_vld, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid en=%b busy=%b vld=%b done=%b expected 0000", meas_en, busy, res_vld, done);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done_seen != d0 || res_seen != r0 || busy !== 1'b0 || res_avg !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_quiet dones=%0d results=%0d busy=%b avg=%0d expected 0 0 0 0",
                     done_seen - d0, res_seen - r0, busy, res_avg);
        end
        exp_q.push_back('{chan: 2'd0, avg: 16'd10, to: 1'b0});
        pulse_start(4'b0001);
        n = 0;
        while (!done && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_fresh_sweep done=%b pending=%0d expected 1 0", done, exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_single;
        test_two_channel;
        test_timeout;
        test_empty;
        test_average;
        test_coincident;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
